hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
//  Sequencer for the iterative multiplier and divider, and owner of the architectural HI/LO registers.
//  The main control unit issues MULT/DIV/MTHI/MTLO with start.
//  hilo_ctrl latches the operands, restarts the selected unit and waits out its fixed latency.
//  It then writes HI/LO and pulses done; busy stalls the main FSM meanwhile.
//  The units have no done/handshake; their local reset is the only start mechanism.
// PARAMETERS
//  MULT_LAT  32  cycles the multiplier needs after its reset is released
//  DIV_LAT   32  cycles the divider needs after its reset is released
//  CNT_W     6   counter width; must hold max(MULT_LAT,DIV_LAT)
// PORTS
//  clk       in   1   clock, all state on posedge
//  reset     in   1   asynchronous, active-high; clears all state
//  start     in   1   issue op; sampled only in IDLE
//  op        in   2   00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//  rs_val    in   32  operand A / MTHI-MTLO source
//  rt_val    in   32  operand B
//  unit_a    out  32  latched operand A to both units
//  unit_b    out  32  latched operand B to both units
//  mul_rst   out  1   multiplier local reset
//  div_rst   out  1   divider local reset
//  mul_hi    in   32  multiplier result, upper word
//  mul_lo    in   32  multiplier result, lower word
//  div_hi    in   32  divider remainder
//  div_lo    in   32  divider quotient
//  hi        out  32  architectural HI
//  lo        out  32  architectural LO
//  busy      out  1   state != IDLE
//  done      out  1   one-cycle pulse: HI/LO update complete
//  div_zero  out  1   one-cycle pulse with done: DIV with rt_val==0
// BEHAVIOUR
//  Reset values:
//   - hi, lo, unit_a, unit_b = 0; done, div_zero, busy = 0; state IDLE.
//   - mul_rst = div_rst = 1 while reset is high (each rst = reset | own CLR pulse).
//  States: IDLE, CLR, RUN, WB; sel register records MULT or DIV.
//  IDLE, start=1, edge E0:
//   - MULT/DIV, rt_val!=0 (or MULT): latch unit_a/unit_b <= rs_val/rt_val; -> CLR.
//   - DIV, rt_val==0: no unit started; hi/lo unchanged; done=1, div_zero=1 for one cycle; stay IDLE.
//   - MTHI/MTLO: hi (or lo) <= rs_val; done=1 next cycle; stay IDLE; busy never asserts.
//  CLR (1 cycle): selected unit's rst=1, other unit's rst=0; counter <= 0; -> RUN at E1.
//  RUN: counter increments each edge; at E(1+LAT) -> WB.
//  WB (1 cycle): at edge E(2+LAT), hi/lo <= sel unit hi/lo; done<=1; -> IDLE.
//  Latency: done high after edge E(2+LAT) (34 edges for default MULT); busy high from E0 to E(2+LAT).
//  unit_a/unit_b held constant from E0 until the next accepted op; units resample B every cycle.
//  start while busy is ignored; no queueing; main FSM must hold until done.
//  op/rs/rt changes during RUN have no effect.
//  Reset mid-operation: immediate abort to IDLE, all registers cleared, no done pulse.
//  Counter never wraps: width checked by assertion against both LAT parameters.
//  Signedness: signed MULT/DIV only; the controller does no arithmetic, only transfer.
// STRUCTURE
//  Shared package: op encodings (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO), state encoding, default latencies.
//  Single FSM file; one natural sub-module: lat_counter (load/enable/terminal-count, width CNT_W).
// TESTING
//  - MULT rs=7, rt=-3 (FFFFFFFD) -> done at edge 34; hi=FFFFFFFF, lo=FFFFFFEB; busy=1 edges 0..34.
//  - DIV rs=100, rt=7 -> lo=14 (0000000E), hi=2 after DIV_LAT+2 edges.
//  - DIV rs=5, rt=0 -> done and div_zero pulse next cycle; hi/lo keep prior values; busy stays 0.
//  - MTHI rs=CAFEBABE, then MTLO rs=12345678 back-to-back -> hi=CAFEBABE, lo=12345678; two done pulses, busy 0.
//  - MULT issued, second start (MTLO) at edge 10 -> ignored; lo = MULT result only.
//  - Reset asserted at edge 15 of a MULT -> hi=lo=0, IDLE, no done; a new MULT then completes normally.

Source files
------------

// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: op encodings, state encodings
// and default unit latencies.
package hilo_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int unsigned DEF_MULT_LAT = 32;
  localparam int unsigned DEF_DIV_LAT  = 32;
  localparam int unsigned DEF_CNT_W    = 6;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hilo_ctrl_lat_counter.sv
// Up-counter with synchronous load-to-zero, count enable and a terminal-count
// flag raised when the count equals the supplied terminal value.
module lat_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO owner and sequencer for the iterative multiplier/divider: latches
// operands, restarts the selected unit via its local reset, waits its latency.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mul_rst,
  output logic        div_rst,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  if (MULT_LAT == 0 || DIV_LAT == 0) begin : g_bad_lat
    $error("hilo_ctrl: unit latencies must be at least 1");
  end
  if (max_lat(MULT_LAT, DIV_LAT) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("hilo_ctrl: CNT_W too narrow for the configured latencies");
  end

  // RUN leaves when the count reaches LAT-1, so WB lands on edge E(2+LAT).
  localparam logic [CNT_W-1:0] MULT_TERM = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_TERM  = CNT_W'(DIV_LAT - 1);

  logic [1:0]       state;
  logic             sel_div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_tc;

  assign cnt_term = sel_div ? DIV_TERM : MULT_TERM;

  lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_CLR),
    .en    (state == ST_RUN),
    .term  (cnt_term),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel_div  <= 1'b0;
      unit_a   <= '0;
      unit_b   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op_e'(op))
              OP_MULT: begin
                unit_a  <= rs_val;
                unit_b  <= rt_val;
                sel_div <= 1'b0;
                state   <= ST_CLR;
              end
              OP_DIV: begin
                if (rt_val == '0) begin
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                end else begin
                  unit_a  <= rs_val;
                  unit_b  <= rt_val;
                  sel_div <= 1'b1;
                  state   <= ST_CLR;
                end
              end
              OP_MTHI: begin
                hi   <= rs_val;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= rs_val;
                done <= 1'b1;
              end
            endcase
          end
        end
        ST_CLR: state <= ST_RUN;
        ST_RUN: begin
          if (cnt_tc) begin
            state <= ST_WB;
          end
        end
        ST_WB: begin
          hi    <= sel_div ? div_hi : mul_hi;
          lo    <= sel_div ? div_lo : mul_lo;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mul_rst = reset | ((state == ST_CLR) & ~sel_div);
  assign div_rst = reset | ((state == ST_CLR) &  sel_div);
  assign busy    = (state != ST_IDLE);

  a_cnt_no_wrap: assert property (@(posedge clk) disable iff (reset)
    (state == ST_RUN) |-> (cnt <= cnt_term));
  a_zero_with_done: assert property (@(posedge clk) disable iff (reset)
    div_zero |-> done);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with behavioural multiplier/divider models that
// only produce valid results LAT cycles after their local reset is released.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int unsigned LAT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] unit_a, unit_b, mul_hi, mul_lo, div_hi, div_lo, hi, lo;
  logic        mul_rst, div_rst, busy, done, div_zero;

  int n_cmp = 0;
  int n_fail = 0;

  hilo_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .unit_a   (unit_a),
    .unit_b   (unit_b),
    .mul_rst  (mul_rst),
    .div_rst  (div_rst),
    .mul_hi   (mul_hi),
    .mul_lo   (mul_lo),
    .div_hi   (div_hi),
    .div_lo   (div_lo),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Unit models: results are garbage until LAT edges after local reset drops.
  int unsigned mcnt = 0;
  int unsigned dcnt = 0;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  always @(posedge clk) begin
    if (mul_rst) mcnt <= 0; else if (mcnt < LAT) mcnt <= mcnt + 1;
    if (div_rst) dcnt <= 0; else if (dcnt < LAT) dcnt <= dcnt + 1;
  end

  assign prod   = $signed(unit_a) * $signed(unit_b);
  assign quo    = (unit_b == '0) ? 32'sd0 : $signed(unit_a) / $signed(unit_b);
  assign rem    = (unit_b == '0) ? 32'sd0 : $signed(unit_a) % $signed(unit_b);
  assign mul_hi = (mcnt == LAT) ? prod[63:32] : 32'hDEADBEEF;
  assign mul_lo = (mcnt == LAT) ? prod[31:0]  : 32'hDEADBEEF;
  assign div_hi = (dcnt == LAT) ? rem         : 32'hBADDCAFE;
  assign div_lo = (dcnt == LAT) ? quo         : 32'hBADDCAFE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start across edge E0 and returns #1 after it.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
    n_cmp++; if ({unit_a, unit_b} !== 64'h0) begin n_fail++; $display("FAIL reset_units: got %h_%h want 0", unit_a, unit_b); end
    n_cmp++; if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/done/dz got %b want 000", {busy, done, div_zero}); end
    n_cmp++; if ({mul_rst, div_rst} !== 2'b11) begin n_fail++; $display("FAIL reset_unit_rst: got %b want 11", {mul_rst, div_rst}); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({mul_rst, div_rst} !== 2'b00) begin n_fail++; $display("FAIL idle_unit_rst: got %b want 00", {mul_rst, div_rst}); end
  endtask

  task automatic test_mult();
    int n = 0;
    int drops = 0;
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD);
    n_cmp++; if ({unit_a, unit_b} !== {32'd7, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL mult_latch: got %h_%h want 00000007_fffffffd", unit_a, unit_b); end
    n_cmp++; if ({busy, mul_rst, div_rst} !== 3'b110) begin n_fail++; $display("FAIL mult_clr: busy/mrst/drst got %b want 110", {busy, mul_rst, div_rst}); end
    while (done !== 1'b1 && n < 100) begin
      tick(); n++;
      if (done !== 1'b1 && busy !== 1'b1) drops++;
      if (n == 1) begin
        n_cmp++; if (mul_rst !== 1'b0) begin n_fail++; $display("FAIL mult_run_rst: got %b want 0", mul_rst); end
      end
    end
    n_cmp++; if (n !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d edges want 34", n); end
    n_cmp++; if (drops !== 0) begin n_fail++; $display("FAIL mult_busy_hold: busy low %0d cycles want 0", drops); end
    n_cmp++; if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin n_fail++; $display("FAIL mult_result: got %h_%h want ffffffff_ffffffeb", hi, lo); end
    n_cmp++; if ({busy, div_zero} !== 2'b00) begin n_fail++; $display("FAIL mult_done_flags: busy/dz got %b want 00", {busy, div_zero}); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div();
    int n = 0;
    issue(OP_DIV, 32'd100, 32'd7);
    n_cmp++; if ({busy, mul_rst, div_rst} !== 3'b101) begin n_fail++; $display("FAIL div_clr: busy/mrst/drst got %b want 101", {busy, mul_rst, div_rst}); end
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 34) begin n_fail++; $display("FAIL div_latency: got %0d edges want 34", n); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL div_result: got %h_%h want 00000002_0000000e", hi, lo); end
    n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_nz_flag: got %b want 0", div_zero); end
    tick();
  endtask

  task automatic test_div_zero();
    issue(OP_DIV, 32'd5, 32'd0);
    n_cmp++; if ({done, div_zero, busy} !== 3'b110) begin n_fail++; $display("FAIL dz_pulse: done/dz/busy got %b want 110", {done, div_zero, busy}); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL dz_hilo_kept: got %h_%h want 00000002_0000000e", hi, lo); end
    n_cmp++; if ({mul_rst, div_rst} !== 2'b00) begin n_fail++; $display("FAIL dz_no_unit: got %b want 00", {mul_rst, div_rst}); end
    tick();
    n_cmp++; if ({done, div_zero, busy} !== 3'b000) begin n_fail++; $display("FAIL dz_after: done/dz/busy got %b want 000", {done, div_zero, busy}); end
  endtask

  task automatic test_back_to_back();
    op = OP_MTHI; rs_val = 32'hCAFEBABE; start = 1'b1;
    tick();
    op = OP_MTLO; rs_val = 32'h12345678;
    n_cmp++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL mthi_done: done/busy got %b want 10", {done, busy}); end
    n_cmp++; if (hi !== 32'hCAFEBABE) begin n_fail++; $display("FAIL mthi_hi: got %h want cafebabe", hi); end
    tick();
    start = 1'b0;
    n_cmp++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL mtlo_done: done/busy got %b want 10", {done, busy}); end
    n_cmp++; if ({hi, lo} !== {32'hCAFEBABE, 32'h12345678}) begin n_fail++; $display("FAIL mt_hilo: got %h_%h want cafebabe_12345678", hi, lo); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mt_done_end: got %b want 0", done); end
  endtask

  task automatic test_start_while_busy();
    int n = 0;
    issue(OP_MULT, 32'd3, 32'd5);
    while (done !== 1'b1 && n < 100) begin
      tick(); n++;
      if (n == 9) begin op = OP_MTLO; rs_val = 32'hAAAAAAAA; rt_val = 32'h0; start = 1'b1; end
      if (n == 12) begin
        start = 1'b0;
        n_cmp++; if ({unit_a, unit_b} !== {32'd3, 32'd5}) begin n_fail++; $display("FAIL busy_units_held: got %h_%h want 00000003_00000005", unit_a, unit_b); end
      end
    end
    n_cmp++; if (n !== 34) begin n_fail++; $display("FAIL busy_latency: got %0d edges want 34", n); end
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd15}) begin n_fail++; $display("FAIL busy_ignored: got %h_%h want 00000000_0000000f", hi, lo); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    int dones = 0;
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD);
    repeat (14) tick();
    reset = 1'b1;
    #1;
    n_cmp++; if ({hi, lo, unit_a, unit_b} !== 128'h0) begin n_fail++; $display("FAIL abort_clear: hi/lo/a/b %h_%h_%h_%h want 0", hi, lo, unit_a, unit_b); end
    n_cmp++; if ({busy, done, mul_rst, div_rst} !== 4'b0011) begin n_fail++; $display("FAIL abort_flags: busy/done/mrst/drst got %b want 0011", {busy, done, mul_rst, div_rst}); end
    tick(); tick();
    reset = 1'b0;
    repeat (40) begin tick(); if (done === 1'b1) dones++; end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD);
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 34) begin n_fail++; $display("FAIL rerun_latency: got %0d edges want 34", n); end
    n_cmp++; if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin n_fail++; $display("FAIL rerun_result: got %h_%h want ffffffff_ffffffeb", hi, lo); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
